// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 word router and its channel slots.
package demux_pkg;

  localparam int NCH        = 4;
  localparam int SELW       = 2;
  localparam int DW_DEFAULT = 32;

  typedef logic [SELW-1:0] chan_sel_t;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic [NCH-1:0] sel_decode(input chan_sel_t sel);
    sel_decode = NCH'(1) << sel;
  endfunction

endpackage

// File: rtl/demux_slot32.sv
// One-entry valid/ready holding register for a single router channel (EMPTY <-> FULL).
module demux_slot32
  import demux_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load_i,
  input  logic          consume_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  slot_state_t   state_q, state_d;
  logic [DW-1:0] data_q, data_d;

  // Next state and data: flush wins, then a load (which also covers refill), then consumption.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (clr) begin
          state_d = SLOT_EMPTY;
        end else if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = data_i;
        end else begin
          state_d = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (clr) begin
          state_d = SLOT_EMPTY;
        end else if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = data_i;
        end else if (consume_i) begin
          state_d = SLOT_EMPTY;
        end else begin
          state_d = SLOT_FULL;
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
      end
    endcase
  end

  // State and data registers; the flush leaves data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/demux4_32_reg.sv
// Registered 1-to-4 router with per-channel valid/ready slots.
// Optional per-channel delivery counters on cnt_all when DEMUX4_CNT_EN is defined.
module demux4_32_reg
  import demux_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  chan_sel_t         in_sel,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [DW-1:0]     out_data0,
  output logic [DW-1:0]     out_data1,
  output logic [DW-1:0]     out_data2,
  output logic [DW-1:0]     out_data3
`ifdef DEMUX4_CNT_EN
  ,
  output logic [NCH*CW-1:0] cnt_all
`endif
);

  logic [NCH-1:0] valid_s;
  logic [NCH-1:0] load_s;
  logic [NCH-1:0] consume_s;
  logic [DW-1:0]  data_s [NCH];

  // Readiness looks only at the selected channel so a stalled consumer never blocks the others.
  assign in_ready = !clr && (!valid_s[in_sel] || out_ready[in_sel]);

  // Steer the accepted word to its channel and flag per-channel deliveries.
  always_comb begin
    load_s    = sel_decode(in_sel) & {NCH{in_valid && in_ready}};
    consume_s = valid_s & out_ready;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    demux_slot32 #(.DW(DW)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .load_i    (load_s[g]),
      .consume_i (consume_s[g]),
      .data_i    (in_data),
      .valid_o   (valid_s[g]),
      .data_o    (data_s[g])
    );
  end

  assign out_valid = valid_s;
  assign out_data0 = data_s[0];
  assign out_data1 = data_s[1];
  assign out_data2 = data_s[2];
  assign out_data3 = data_s[3];

`ifdef DEMUX4_CNT_EN
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];

  // A flush overrides the consumer handshake, so it does not count as a delivery.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      if (!clr && consume_s[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Delivery counter registers, wrapping naturally at 2^CW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign cnt_all[g*CW +: CW] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_demux4_32_reg.sv
// Directed self-checking bench for demux4_32_reg (counter checks active with DEMUX4_CNT_EN).
module tb_demux4_32_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX4_CNT_EN
  logic [63:0] cnt_all;
`endif

  int errors = 0;
  int checks = 0;

  demux4_32_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
`ifdef DEMUX4_CNT_EN
    ,
    .cnt_all   (cnt_all)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; in_sel = 2'd1;
    out_ready = 4'b0000;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick(); tick();
    check("rst_nothing_latched", {60'd0, out_valid}, 64'h0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_valid", {60'd0, out_valid}, 64'h0);
    check("idle_data", {out_data0 | out_data1, out_data2 | out_data3}, 64'h0);
`ifdef DEMUX4_CNT_EN
    check("idle_cnt", cnt_all, 64'h0);
`endif

    // Channel 2 stalls; a second word to it is refused, channel 0 still accepted.
    in_valid = 1'b1; in_data = 32'h1; in_sel = 2'd2;
    #1;
    check("ch2_first_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("ch2_valid", {60'd0, out_valid}, 64'h4);
    check("ch2_data", {32'd0, out_data2}, 64'h1);
    in_data = 32'h2;
    #1;
    check("ch2_blocked", {63'd0, in_ready}, 64'd0);
    tick();
    check("ch2_held", {32'd0, out_data2}, 64'h1);
    in_sel = 2'd0; in_data = 32'hA;
    #1;
    check("ch0_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("ch0_valid", {60'd0, out_valid}, 64'h5);
    check("ch0_data", {32'd0, out_data0}, 64'hA);

    // Channel 3 streaming with no bubbles.
    out_ready = 4'b1000; in_sel = 2'd3;
    for (int k = 1; k <= 4; k++) begin
      in_data = 32'(k);
      #1;
      check($sformatf("ch3_ready_%0d", k), {63'd0, in_ready}, 64'd1);
      tick();
      check($sformatf("ch3_data_%0d", k), {32'd0, out_data3}, 64'(k));
      check($sformatf("ch3_valid_%0d", k), {60'd0, out_valid}, 64'hD);
    end
    in_valid = 1'b0;
    tick();
    check("ch3_drained", {60'd0, out_valid}, 64'h5);
    check("ch0_ch2_hold", {out_data0, out_data2}, {32'hA, 32'h1});

    // Simultaneous consume and refill on channel 1.
    out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h5;
    tick();
    check("ch1_five", {32'd0, out_data1}, 64'h5);
    out_ready = 4'b0010; in_data = 32'h6;
    #1;
    check("ch1_refill_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("ch1_six", {32'd0, out_data1}, 64'h6);
    check("ch1_valid_kept", {60'd0, out_valid}, 64'h7);
`ifdef DEMUX4_CNT_EN
    check("cnt1_after_refill", {48'd0, cnt_all[31:16]}, 64'd1);
    check("cnt3_stream", {48'd0, cnt_all[63:48]}, 64'd4);
`endif
    in_valid = 1'b0;
    tick();
    check("ch1_drained", {60'd0, out_valid}, 64'h5);

    // Fill all channels, then flush with a competing input.
    out_ready = 4'b0000; in_valid = 1'b1;
    in_sel = 2'd1; in_data = 32'h7; tick();
    in_sel = 2'd3; in_data = 32'h8; tick();
    check("all_full", {60'd0, out_valid}, 64'hF);
    clr = 1'b1; out_ready = 4'b1111; in_sel = 2'd0; in_data = 32'hBAD;
    #1;
    check("clr_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    clr = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    check("clr_valid", {60'd0, out_valid}, 64'h0);
    check("clr_no_capture", {32'd0, out_data0}, 64'hA);
`ifdef DEMUX4_CNT_EN
    check("clr_cnt", cnt_all, {16'd4, 16'd0, 16'd2, 16'd0});

    // Counter 0 wrap: 65536 loads give 65535 deliveries, one more wraps to zero.
    in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'b0001;
    for (int k = 0; k < 65536; k++) begin
      tick();
    end
    check("cnt0_ffff", {48'd0, cnt_all[15:0]}, 64'hFFFF);
    in_valid = 1'b0;
    tick();
    check("cnt0_wrap", {48'd0, cnt_all[15:0]}, 64'h0);
    out_ready = 4'b0000;
`endif

    // Asynchronous reset mid-stream.
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hC;
    tick();
    check("pre_reset_valid", {60'd0, out_valid}, 64'h4);
    check("pre_reset_data", {32'd0, out_data2}, 64'hC);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {60'd0, out_valid}, 64'h0);
    check("async_rst_data", {32'd0, out_data2}, 64'h0);
`ifdef DEMUX4_CNT_EN
    check("async_rst_cnt", cnt_all, 64'h0);
`endif
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {60'd0, out_valid}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
